// File: rtl/breadboard_sweeper_if.sv
// Signal bundle between the sweeper, the breadboard under test and the board controller.
// start is a level sampled only when the sweeper is IDLE; done is a one-cycle pulse; no back-pressure.
interface breadboard_sweeper_if;
  logic       start;
  logic       w;
  logic       x;
  logic       y;
  logic       z;
  logic [9:0] resp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       err_valid;
  logic [3:0] first_err_idx;
  logic [3:0] rd_addr;
  logic [9:0] rd_data;

  modport slave (
    input  start, resp, rd_addr,
    output w, x, y, z, busy, done, pass, err_count, err_valid, first_err_idx, rd_data
  );

  modport master (
    output start, resp, rd_addr,
    input  w, x, y, z, busy, done, pass, err_count, err_valid, first_err_idx, rd_data
  );
endinterface

// File: rtl/breadboard_sweeper.sv
// Walks all 16 (w,x,y,z) vectors, samples the 10 breadboard responses after a settle
// delay, stores them in a capture table and scores them against a golden table.
module breadboard_sweeper #(
  parameter int unsigned  SETTLE_CYCLES = 3,
  parameter logic [159:0] GOLDEN        = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  breadboard_sweeper_if.slave         bb,
  output logic [1:0]                  state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  vec_q, vec_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic [4:0]  err_count_q, err_count_d;
  logic        err_valid_q, err_valid_d;
  logic [3:0]  first_err_q, first_err_d;
  logic        cap_we;
  logic [9:0]  capture_q [16];
  logic [9:0]  rd_data_q;
  logic [9:0]  golden_cur;
  logic        mismatch;

  // Constant-index mux keeps the golden lookup free of variable part-selects.
  always_comb begin
    golden_cur = '0;
    for (int i = 0; i < 16; i++) begin
      if (idx_q == 4'(i)) golden_cur = GOLDEN[i*10 +: 10];
    end
  end

  assign mismatch = (bb.resp != golden_cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_valid_q <= 1'b0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_valid_q <= err_valid_d;
      first_err_q <= first_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_valid_d = err_valid_q;
    first_err_d = first_err_q;
    cap_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bb.start) begin
          idx_d       = '0;
          vec_d       = '0;
          cnt_d       = SETTLE_LD;
          busy_d      = 1'b1;
          err_count_d = '0;
          err_valid_d = 1'b0;
          first_err_d = '0;
          pass_d      = 1'b0;
          state_d     = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == 8'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end

      SAMPLE: begin
        cap_we = 1'b1;
        if (mismatch) begin
          err_count_d = err_count_q + 5'd1;
          if (!err_valid_q) begin
            first_err_d = idx_q;
            err_valid_d = 1'b1;
          end
        end
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          vec_d   = idx_q + 4'd1;
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        // err_count_q already includes any mismatch from the final SAMPLE.
        pass_d  = (err_count_q == 5'd0);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Read sees the pre-write contents when it hits the entry being captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) capture_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (cap_we) capture_q[idx_q] <= bb.resp;
      rd_data_q <= capture_q[bb.rd_addr];
    end
  end

  assign bb.w             = vec_q[3];
  assign bb.x             = vec_q[2];
  assign bb.y             = vec_q[1];
  assign bb.z             = vec_q[0];
  assign bb.busy          = busy_q;
  assign bb.done          = (state_q == DONE);
  assign bb.pass          = pass_q;
  assign bb.err_count     = err_count_q;
  assign bb.err_valid     = err_valid_q;
  assign bb.first_err_idx = first_err_q;
  assign bb.rd_data       = rd_data_q;
  assign state_o          = state_q;

endmodule
